noc_inject_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one router local receive port among `NUM_REQ` local requesters (test nodes, DMA engines, CSR masters) on the same tile. It grants a requester on a header flit and holds the grant until the tail flit, so flits from different packets never interleave. A registered output stage drives the router's `Noc_x_y_receive_*` port.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/noc_rr_picker.sv | 35 +++
 rtl/noc_inject_arbiter.sv | 158 +++++++++++++++
 tb/tb_noc_inject_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC local-injection arbiter: FSM encoding,
// default counter width, flit sideband layout and a small index helper.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

package noc_pkg;

  localparam logic [0:0] ARB_IDLE   = 1'b0;
  localparam logic [0:0] ARB_LOCKED = 1'b1;

  localparam int STAT_W_DEFAULT = 16;

  typedef struct packed {
    logic is_header;
    logic is_tail;
  } flit_side_t;

  // Next requester index after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/noc_rr_picker.sv
// Combinational rotating-priority encoder: first set request at or after
// i_ptr, wrapping, reported as one-hot, binary index and any-valid.
module noc_rr_picker
  import noc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  assign o_any = |i_req;

  always_comb begin
    int   j;
    logic found;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    j       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      j = (int'(i_ptr) + off) % NUM_REQ;
      if (!found && i_req[j]) begin
        o_grant[j] = 1'b1;
        o_idx      = IDX_W'(j);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-level round-robin arbiter sharing one router receive port among
// NUM_REQ local requesters. Optional packet counters: NOC_INJECT_ARB_STATS_EN.
module noc_inject_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = `Noc_Data_Width,
  parameter int STAT_W  = STAT_W_DEFAULT
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_is_header,
  input  logic [NUM_REQ-1:0]        req_is_tail,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_flit,
  output logic                      out_is_header,
  output logic                      out_is_tail,
  output logic                      err_no_header,
  output logic [NUM_REQ*STAT_W-1:0] stat_pkt_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [0:0]         r_state;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_flit;
  flit_side_t         r_out_side;
  logic               r_err;

  logic               w_load;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_accept;
  logic [DATA_W-1:0]  w_sel_flit;
  flit_side_t         w_sel_side;
  logic               w_hdr_missing;

  // Handshake: a flit moves on a requester port in any cycle where both
  // req_valid[i] and req_ready[i] are high at the rising edge; likewise on
  // the output port when out_valid and out_ready are both high.
  assign w_load = !r_out_valid || out_ready;
  assign w_cand = req_valid & req_is_header;

  noc_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req   (w_cand),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_onehot),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_comb begin
    req_ready = '0;
    if (!noc_rst && w_load) begin
      if (r_state == ARB_IDLE) req_ready = w_pick_onehot;
      else                     req_ready[r_grant_idx] = 1'b1;
    end
  end

  assign w_sel_idx = (r_state == ARB_IDLE) ? w_pick_idx : r_grant_idx;
  assign w_accept  = |(req_valid & req_ready);

  always_comb begin
    w_sel_flit = '0;
    w_sel_side = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == w_sel_idx) begin
        w_sel_flit           = req_flit[i*DATA_W +: DATA_W];
        w_sel_side.is_header = req_is_header[i];
        w_sel_side.is_tail   = req_is_tail[i];
      end
    end
  end

  // A body flit offered while idle is never granted; flag it only when no
  // legitimate header is competing in the same cycle.
  assign w_hdr_missing = (r_state == ARB_IDLE) && !w_pick_any &&
                         (|(req_valid & ~req_is_header));

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      r_state     <= ARB_IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      if (r_state == ARB_IDLE) begin
        if (!w_sel_side.is_tail) begin
          r_state     <= ARB_LOCKED;
          r_grant_idx <= w_pick_idx;
        end else begin
          r_rr_ptr <= IDX_W'(wrap_inc(int'(w_pick_idx), NUM_REQ));
        end
      end else if (w_sel_side.is_tail) begin
        r_state  <= ARB_IDLE;
        r_rr_ptr <= IDX_W'(wrap_inc(int'(r_grant_idx), NUM_REQ));
      end
    end
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_out_side  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_flit  <= w_sel_flit;
      r_out_side  <= w_sel_side;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst)            r_err <= 1'b0;
    else if (w_hdr_missing) r_err <= 1'b1;
  end

  assign out_valid     = r_out_valid;
  assign out_flit      = r_out_flit;
  assign out_is_header = r_out_side.is_header;
  assign out_is_tail   = r_out_side.is_tail;
  assign err_no_header = r_err;

`ifdef NOC_INJECT_ARB_STATS_EN
  logic [NUM_REQ*STAT_W-1:0] r_stat_cnt;

  // Counts completed packets per requester; saturates instead of wrapping.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      r_stat_cnt <= '0;
    end else if (w_accept && w_sel_side.is_tail) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (IDX_W'(i) == w_sel_idx &&
            r_stat_cnt[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})
          r_stat_cnt[i*STAT_W +: STAT_W] <= r_stat_cnt[i*STAT_W +: STAT_W] + STAT_W'(1);
      end
    end
  end

  assign stat_pkt_cnt = r_stat_cnt;
`else
  assign stat_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter: per-requester flit sources, an
// expected-output queue and a monitor that checks every output handshake.
module tb_noc_inject_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int STAT_W  = 4;
  localparam int EW      = DATA_W + 2;

`ifdef NOC_INJECT_ARB_STATS_EN
  localparam logic [STAT_W-1:0] EXP_S1 = 4'd15;
  localparam logic [STAT_W-1:0] EXP_S3 = 4'd1;
`else
  localparam logic [STAT_W-1:0] EXP_S1 = 4'd0;
  localparam logic [STAT_W-1:0] EXP_S3 = 4'd0;
`endif

  logic                      noc_clk;
  logic                      noc_rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_flit;
  logic [NUM_REQ-1:0]        req_is_header;
  logic [NUM_REQ-1:0]        req_is_tail;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_flit;
  logic                      out_is_header;
  logic                      out_is_tail;
  logic                      err_no_header;
  logic [NUM_REQ*STAT_W-1:0] stat_pkt_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] src_q[NUM_REQ][$];

  noc_inject_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .STAT_W  (STAT_W)
  ) dut (
    .noc_clk       (noc_clk),
    .noc_rst       (noc_rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_flit      (req_flit),
    .req_is_header (req_is_header),
    .req_is_tail   (req_is_tail),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_flit      (out_flit),
    .out_is_header (out_is_header),
    .out_is_tail   (out_is_tail),
    .err_no_header (err_no_header),
    .stat_pkt_cnt  (stat_pkt_cnt)
  );

  // ---------------- clock / reset ----------------
  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [EW-1:0] fl(input logic h, input logic t, input logic [DATA_W-1:0] d);
    return {h, t, d};
  endfunction

  function automatic bit src_empty();
    for (int i = 0; i < NUM_REQ; i++)
      if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge noc_clk);
  endtask

  task automatic send(input int r, input logic [EW-1:0] f, input bit expect_out);
    src_q[r].push_back(f);
    if (expect_out) exp_q.push_back(f);
  endtask

  task automatic send_pkt(input int r, input logic [DATA_W-1:0] base, input int len, input bit expect_out);
    for (int k = 0; k < len; k++)
      send(r, fl(k == 0, k == len - 1, base + DATA_W'(k)), expect_out);
  endtask

  task automatic exp_pkt(input logic [DATA_W-1:0] base, input int len);
    for (int k = 0; k < len; k++)
      exp_q.push_back(fl(k == 0, k == len - 1, base + DATA_W'(k)));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !src_empty()) && n < budget) begin
      tick();
      n++;
    end
    n_tests++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s: drain timeout, got %0d flits still pending, expected 0", name, exp_q.size());
    end
    tick();
    tick();
  endtask

  // ---------------- driver: one source queue per requester ----------------
  initial begin
    logic [NUM_REQ-1:0] fire;
    req_valid     = '0;
    req_is_header = '0;
    req_is_tail   = '0;
    req_flit      = '0;
    forever begin
      @(negedge noc_clk);
      fire = req_valid & req_ready;
      @(posedge noc_clk);
      #2;
      for (int i = 0; i < NUM_REQ; i++)
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      for (int i = 0; i < NUM_REQ; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          {req_is_header[i], req_is_tail[i], req_flit[i*DATA_W +: DATA_W]} = src_q[i][0];
        end else begin
          req_valid[i]     = 1'b0;
          req_is_header[i] = 1'b0;
          req_is_tail[i]   = 1'b0;
          req_flit[i*DATA_W +: DATA_W] = '0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    forever begin
      @(negedge noc_clk);
      if (out_valid && out_ready) begin
        got = {out_is_header, out_is_tail, out_flit};
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got 0x%0h, expected no output", got);
        end else begin
          want = exp_q.pop_front();
          check("out_flit_order", 32'(got), 32'(want));
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    noc_rst   = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();

    // Reset values; a single-flit header waits on req0 while reset is high.
    send(0, fl(1'b1, 1'b1, 16'h0001), 1'b1);
    at_neg();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_flit", 32'(out_flit), 32'h0);
    check("rst_out_sideband", 32'({out_is_header, out_is_tail}), 32'h0);
    check("rst_err", 32'(err_no_header), 32'h0);
    check("rst_stats", 32'(stat_pkt_cnt), 32'h0);
    tick();
    noc_rst = 1'b0;

    // Single-flit packet: granted now, visible next cycle for one cycle.
    at_neg();
    check("single_grant", 32'(req_ready), 32'h1);
    check("single_not_yet", 32'(out_valid), 32'h0);
    at_neg();
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_flit", 32'({out_is_header, out_is_tail, out_flit}), 32'(fl(1'b1, 1'b1, 16'h0001)));
    at_neg();
    check("single_one_cycle", 32'(out_valid), 32'h0);

    // rr_ptr is 1 now: req1 beats req0, then pointer at 2 picks req0.
    tick();
    send(0, fl(1'b1, 1'b1, 16'h1000), 1'b0);
    send(1, fl(1'b1, 1'b1, 16'h1001), 1'b0);
    exp_q.push_back(fl(1'b1, 1'b1, 16'h1001));
    exp_q.push_back(fl(1'b1, 1'b1, 16'h1000));
    at_neg();
    check("rr_ptr_after_single", 32'(req_ready), 32'h2);
    wait_drain("rr_drain", 50);

    // Fairness: rr_ptr is 1, so req2 goes first, then alternation, no interleave.
    send_pkt(0, 16'hA000, 3, 1'b0);
    send_pkt(0, 16'hA003, 3, 1'b0);
    send_pkt(2, 16'hC000, 3, 1'b0);
    send_pkt(2, 16'hC003, 3, 1'b0);
    exp_pkt(16'hC000, 3);
    exp_pkt(16'hA000, 3);
    exp_pkt(16'hC003, 3);
    exp_pkt(16'hA003, 3);
    wait_drain("fair_drain", 100);

    // Backpressure: second flit held for 5 cycles with no acceptance.
    send_pkt(1, 16'hB000, 4, 1'b1);
    tick();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      check("bp_valid_held", 32'(out_valid), 32'h1);
      check("bp_flit_held", 32'({out_is_header, out_is_tail, out_flit}), 32'(fl(1'b0, 1'b0, 16'hB001)));
      check("bp_req_ready", 32'(req_ready), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    wait_drain("bp_drain", 50);

    // Protocol error: body flit on req1 while idle.
    send(1, fl(1'b0, 1'b0, 16'hE000), 1'b0);
    at_neg();
    check("perr_ready", 32'(req_ready), 32'h0);
    check("perr_err_not_yet", 32'(err_no_header), 32'h0);
    at_neg();
    check("perr_err_set", 32'(err_no_header), 32'h1);
    check("perr_ready_next", 32'(req_ready[1]), 32'h0);
    tick();
    src_q[1].delete();
    send(2, fl(1'b1, 1'b1, 16'h2222), 1'b1);
    wait_drain("perr_drain", 50);
    check("perr_err_sticky", 32'(err_no_header), 32'h1);

    // Reset mid-packet: D0 delivered, D1 held in the output register, then reset.
    out_ready = 1'b0;
    send_pkt(0, 16'hD000, 4, 1'b0);
    exp_q.push_back(fl(1'b1, 1'b0, 16'hD000));
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    at_neg();
    check("mid_held_flit", 32'({out_valid, out_flit}), 32'({1'b1, 16'hD001}));
    tick();
    noc_rst = 1'b1;
    src_q[0].delete();
    send(3, fl(1'b1, 1'b1, 16'h3333), 1'b1);
    at_neg();
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    at_neg();
    check("mid_rst_out_valid", 32'(out_valid), 32'h0);
    check("mid_rst_out_flit", 32'(out_flit), 32'h0);
    check("mid_rst_sideband", 32'({out_is_header, out_is_tail}), 32'h0);
    check("mid_rst_err", 32'(err_no_header), 32'h0);
    check("mid_rst_stats", 32'(stat_pkt_cnt), 32'h0);
    tick();
    noc_rst   = 1'b0;
    out_ready = 1'b1;
    at_neg();
    check("post_rst_grant_req3", 32'(req_ready), 32'h8);
    wait_drain("post_rst_drain", 50);

    // Statistics: 17 single-flit packets from req1.
    for (int k = 0; k < 17; k++)
      send(1, fl(1'b1, 1'b1, 16'h5000 + DATA_W'(k)), 1'b1);
    wait_drain("stat_drain", 200);
    check("stat_req0", 32'(stat_pkt_cnt[0*STAT_W +: STAT_W]), 32'h0);
    check("stat_req1", 32'(stat_pkt_cnt[1*STAT_W +: STAT_W]), 32'(EXP_S1));
    check("stat_req2", 32'(stat_pkt_cnt[2*STAT_W +: STAT_W]), 32'h0);
    check("stat_req3", 32'(stat_pkt_cnt[3*STAT_W +: STAT_W]), 32'(EXP_S3));

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    check("final_idle", 32'(out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
